main_memory: RTL

- Block-granular backing-store model directly downstream of the L2 cache. Serves the L2 miss/fill port: mem_addr, mem_read, mem_write, mem_ready, mem_hit, and block-wide data.
- Programmable access latency, with a single open-row buffer that gives shorter latency on row hits.
- Used in simulation and FPGA bring-up as the last level of the memory hierarchy.

---
 rtl/main_memory.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/main_memory.sv
// Block-granular backing store behind the L2 cache, with programmable access latency.
// Define MAIN_MEMORY_ROW_BUFFER_EN to add a single open-row buffer that shortens row-hit latency.
module main_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BLOCK_SIZE   = 16,
    parameter int MEM_BLOCKS   = 256,
    parameter int ROW_BLOCKS   = 4,
    parameter int MISS_LATENCY = 8,
    parameter int HIT_LATENCY  = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
    input  logic                                  mem_read,
    input  logic                                  mem_write,
    output logic                                  mem_ready,
    output logic                                  mem_hit
);
    localparam int BOW = $clog2(BLOCK_SIZE);
    localparam int IW  = $clog2(MEM_BLOCKS);
    localparam logic [7:0] MISS_LAT = 8'(MISS_LATENCY);

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
    typedef block_t mem_t [MEM_BLOCKS];
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int b = 0; b < MEM_BLOCKS; b++) begin
            for (int w = 0; w < BLOCK_SIZE; w++) begin
                m[b][w] = DATA_WIDTH'((b << 16) | w);
            end
        end
        return m;
    endfunction

    // NOTE: the storage array has no reset; contents survive rst_n and only the
    // time-zero image is defined, so it can map onto block RAM.
    mem_t storage = init_mem();

    state_t          state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [IW-1:0]   req_idx, idx, resp_idx;
    logic            op_write, resp_wr, hit_q, row_hit, accept, enter_resp;
    block_t          wdata;
    logic [7:0]      lat;
    logic            unused_addr;

    assign req_idx     = mem_addr[BOW +: IW];
    assign unused_addr = ^mem_addr;
    assign accept      = (state == IDLE) && (mem_read || mem_write);

`ifdef MAIN_MEMORY_ROW_BUFFER_EN
    localparam int RBW = $clog2(ROW_BLOCKS);
    localparam int RW  = IW - RBW;
    localparam logic [7:0] HIT_LAT = 8'(HIT_LATENCY);

    logic [RW-1:0] req_row, open_row;
    logic          row_valid;

    assign req_row = req_idx[IW-1:RBW];
    assign row_hit = row_valid && (open_row == req_row);
    assign lat     = row_hit ? HIT_LAT : MISS_LAT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_row  <= '0;
            row_valid <= 1'b0;
        end else if (accept) begin
            open_row  <= req_row;
            row_valid <= 1'b1;
        end
    end
`else
    assign row_hit = 1'b0;
    assign lat     = MISS_LAT;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (lat == 8'd1) begin
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = lat - 8'd2;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == 8'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 8'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A single-cycle access enters RESP straight from IDLE, before the request is latched.
    assign resp_idx   = (state == IDLE) ? req_idx   : idx;
    assign resp_wr    = (state == IDLE) ? mem_write : op_write;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            op_write     <= 1'b0;
            wdata        <= '0;
            hit_q        <= 1'b0;
            mem_data_out <= '0;
        end else begin
            if (accept) begin
                idx      <= req_idx;
                op_write <= mem_write;
                wdata    <= mem_data_in;
                hit_q    <= row_hit;
            end
            if (enter_resp && !resp_wr) mem_data_out <= storage[resp_idx];
        end
    end

    // Commit on the edge leaving RESP; a reset forces IDLE, which drops any in-flight write.
    always_ff @(posedge clk) begin
        if (state == RESP && op_write) storage[idx] <= wdata;
    end

    assign mem_ready = (state == RESP);
    assign mem_hit   = (state == RESP) && hit_q;

endmodule
